fetch_stage: RTL and testbench

//  Instruction fetch stage of the pipelined ARM-subset core; the requesting side of the

---
 rtl/core_pkg.sv | 19 +
 rtl/pc_register.sv | 16 +
 rtl/fetch_stage.sv | 50 +++++
 tb/tb_fetch_stage.sv | 132 +++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared widths, constants and ARM field encodings for the pipelined core
package core_pkg;
  localparam int WORD_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [WORD_W-1:0] RESET_PC = 32'h0000_0000;
  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;
  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } opcode_e;
endpackage

// File: rtl/pc_register.sv
// pc_register: N-bit program counter with synchronous reset and load enable
module pc_register #(
  parameter int N = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  logic [N-1:0] pc_q;
  // hold unless loaded; reset wins
  always_ff @(posedge clk) pc_q <= rst ? RESET_PC : ld ? d : pc_q;
  assign q = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction memory request and IF/ID register with freeze/flush/redirect
module fetch_stage
  import core_pkg::*;
#(
  parameter int N = WORD_W,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter logic [N-1:0] NOP_INSTR = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         flush,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_addr,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_instr,
  output logic [N-1:0] if_pc,
  output logic [N-1:0] if_instr,
  output logic         if_valid
);
  localparam logic [N-1:0] STEP = N'(PC_STEP);
  logic [N-1:0] pc_q, pc_d, pc_plus4, if_pc_q, if_pc_d, if_instr_q, if_instr_d;
  logic         if_valid_q, if_valid_d, bubble;
  pc_register #(.N(N), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst(rst),
    .ld (~freeze | branch_taken),
    .d  (pc_d),
    .q  (pc_q)
  );
  // next PC and IF/ID contents: branch > flush > freeze > normal
  always_comb begin
    pc_plus4 = pc_q + STEP;
    bubble = branch_taken | flush;
    pc_d = branch_taken ? {branch_addr[N-1:2], 2'b00} : pc_plus4;
    if_pc_d = bubble ? '0 : freeze ? if_pc_q : pc_plus4;
    if_instr_d = bubble ? NOP_INSTR : freeze ? if_instr_q : imem_instr;
    if_valid_d = bubble ? 1'b0 : freeze ? if_valid_q : 1'b1;
  end
  // IF/ID pipeline register
  always_ff @(posedge clk) begin
    if_pc_q <= rst ? '0 : if_pc_d;
    if_instr_q <= rst ? NOP_INSTR : if_instr_d;
    if_valid_q <= rst ? 1'b0 : if_valid_d;
  end
  assign imem_addr = pc_q;
  assign if_pc = if_pc_q;
  assign if_instr = if_instr_q;
  assign if_valid = if_valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench with a behavioural fetch model, two reset PCs
module tb_fetch_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] ifi;
    logic        ifv;
  } exp_t;

  logic clk = 1'b0;
  logic rst, freeze, flush, branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] a0, a1, i0, i1, p0, p1, n0, n1;
  logic v0, v1;
  exp_t q0[$], q1[$];
  exp_t m[2];
  logic [31:0] rpc[2];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'hE3A00014;
    if (a == 32'd112) return 32'hE0804103;
    return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
  endfunction

  assign i0 = mem_word(a0);
  assign i1 = mem_word(a1);

  fetch_stage #(.N(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0)) d0 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_addr(a0), .imem_instr(i0), .if_pc(p0), .if_instr(n0), .if_valid(v0)
  );
  fetch_stage #(.N(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0)) d1 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_addr(a1), .imem_instr(i1), .if_pc(p1), .if_instr(n1), .if_valid(v1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // drive one cycle of inputs and push the state each design must show after the edge
  task automatic step(input logic r, input logic b, input logic [31:0] ba,
                      input logic fl, input logic fz);
    @(negedge clk);
    rst = r; branch_taken = b; branch_addr = ba; flush = fl; freeze = fz;
    for (int k = 0; k < 2; k++) begin
      if (r) m[k] = '{rpc[k], 32'h0, 32'h0, 1'b0};
      else if (b) m[k] = '{ba & ~32'd3, 32'h0, 32'h0, 1'b0};
      else if (fl) m[k] = '{fz ? m[k].pc : m[k].pc + 32'd4, 32'h0, 32'h0, 1'b0};
      else if (!fz) m[k] = '{m[k].pc + 32'd4, m[k].pc + 32'd4, mem_word(m[k].pc), 1'b1};
      if (k == 0) q0.push_back(m[k]);
      else q1.push_back(m[k]);
    end
  endtask

  // monitor: compare whatever each design presents against the oldest expectation
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("d0.imem_addr", a0, e.pc);
      chk("d0.if_pc", p0, e.ifpc);
      chk("d0.if_instr", n0, e.ifi);
      chk("d0.if_valid", {31'b0, v0}, {31'b0, e.ifv});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("d1.imem_addr", a1, e.pc);
      chk("d1.if_pc", p1, e.ifpc);
      chk("d1.if_instr", n1, e.ifi);
      chk("d1.if_valid", {31'b0, v1}, {31'b0, e.ifv});
      chk("d1.align", {30'b0, a1[1:0]}, 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    rpc[0] = 32'h0000_0000;
    rpc[1] = 32'hFFFF_FFFC;
    m[0] = '{32'h0, 32'h0, 32'h0, 1'b0};
    m[1] = m[0];
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    while (m[0].pc != 32'd20) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'd112, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'h8B, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'd40, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 1, 32'h44, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("drain", q0.size() + q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
